// File: rtl/oq_rate_limiter.sv
// Per-port token-bucket shaper between an output queue and its transmit queue.
// Packets are admitted whole once the bucket covers their IOQ byte length, then forwarded unchanged.
module oq_rate_limiter #(
  parameter int unsigned              DATA_WIDTH      = 64,
  parameter int unsigned              CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned              TOKEN_WIDTH     = 20,
  parameter logic [CTRL_WIDTH-1:0]    IOQ_CTRL        = 8'hFF,
  parameter int unsigned              FIFO_DEPTH_BITS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  input  logic                   in_wr,
  output logic                   in_rdy,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic                   out_wr,
  input  logic                   out_rdy,
  input  logic                   cfg_enable,
  input  logic [15:0]            cfg_inc,
  input  logic [15:0]            cfg_interval,
  input  logic [TOKEN_WIDTH-1:0] cfg_bucket_max,
  output logic [TOKEN_WIDTH-1:0] tokens,
  output logic                   pkt_sent,
  output logic                   pkt_delayed
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_BITS;
  localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;
  localparam int unsigned TokW  = TOKEN_WIDTH + 2;

  typedef enum logic [0:0] {StHead, StSend} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]      mem_data [Depth];
  logic [CTRL_WIDTH-1:0]      mem_ctrl [Depth];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]            count_q, count_d;
  logic                       fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [CTRL_WIDTH-1:0]      head_ctrl;
  logic [15:0]                head_len;

  logic                       admit, admit_go, deduct, delay_hit, eop_rd;
  logic                       delayed_q, delayed_d;
  logic [CTRL_WIDTH-1:0]      prev_ctrl_q;

  logic [15:0]                int_limit, int_cnt_q, int_cnt_d;
  logic                       refill;
  logic [TokW-1:0]            tok_sum;
  logic [TOKEN_WIDTH-1:0]     tokens_q, tokens_d;

  logic                       out_wr_q, pkt_sent_q, pkt_delayed_q;
  logic [DATA_WIDTH-1:0]      out_data_q;
  logic [CTRL_WIDTH-1:0]      out_ctrl_q;

  // Fallthrough input FIFO: the head word is visible combinationally.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(Depth));
  assign fifo_wr    = in_wr && !fifo_full;
  assign in_rdy     = (count_q < CntW'(Depth - 2));
  assign head_data  = mem_data[rd_ptr_q];
  assign head_ctrl  = mem_ctrl[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_q] <= in_data;
      mem_ctrl[wr_ptr_q] <= in_ctrl;
    end
  end

  always_comb begin
    count_d = count_q;
    if (fifo_wr && !fifo_rd) begin
      count_d = count_q + CntW'(1);
    end else if (!fifo_wr && fifo_rd) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_BITS'(1);
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_BITS'(1);
      count_q <= count_d;
    end
  end

  // Admission decision on the packet head.
  assign head_len = (head_ctrl == IOQ_CTRL) ? head_data[15:0] : 16'd0;
  assign admit    = !cfg_enable || ({2'b00, tokens_q} >= TokW'(head_len));
  assign eop_rd   = fifo_rd && (head_ctrl != '0) && (prev_ctrl_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StHead;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHead: if (admit_go) state_d = StSend;
      StSend: if (eop_rd) state_d = StHead;
      default: state_d = StHead;
    endcase
  end

  always_comb begin
    fifo_rd   = 1'b0;
    deduct    = 1'b0;
    delay_hit = 1'b0;
    admit_go  = 1'b0;
    unique case (state_q)
      StHead: begin
        if (!fifo_empty) begin
          if (admit) begin
            admit_go = 1'b1;
            deduct   = cfg_enable;
            fifo_rd  = out_rdy;
          end else begin
            delay_hit = !delayed_q;
          end
        end
      end
      StSend: fifo_rd = !fifo_empty && out_rdy;
      default: ;
    endcase
  end

  // One pkt_delayed pulse per stalled packet; rearmed on admission.
  assign delayed_d = admit_go ? 1'b0 : (delayed_q || delay_hit);

  // Refill timer; comparing with >= lets a lowered interval wrap promptly.
  assign int_limit = (cfg_interval == 16'd0) ? 16'd1 : cfg_interval;
  assign refill    = (int_cnt_q >= int_limit - 16'd1);
  assign int_cnt_d = refill ? 16'd0 : int_cnt_q + 16'd1;

  always_comb begin
    tok_sum = {2'b00, tokens_q};
    if (refill) tok_sum = tok_sum + TokW'(cfg_inc);
    if (deduct) tok_sum = tok_sum - TokW'(head_len);
    tokens_d = (tok_sum > TokW'(cfg_bucket_max)) ? cfg_bucket_max : tok_sum[TOKEN_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tokens_q      <= '0;
      int_cnt_q     <= '0;
      delayed_q     <= 1'b0;
      prev_ctrl_q   <= CTRL_WIDTH'(1);
      out_wr_q      <= 1'b0;
      out_data_q    <= '0;
      out_ctrl_q    <= '0;
      pkt_sent_q    <= 1'b0;
      pkt_delayed_q <= 1'b0;
    end else begin
      tokens_q      <= tokens_d;
      int_cnt_q     <= int_cnt_d;
      delayed_q     <= delayed_d;
      out_wr_q      <= fifo_rd;
      pkt_sent_q    <= eop_rd;
      pkt_delayed_q <= delay_hit;
      if (fifo_rd) begin
        prev_ctrl_q <= head_ctrl;
        out_data_q  <= head_data;
        out_ctrl_q  <= head_ctrl;
      end
    end
  end

  assign out_wr      = out_wr_q;
  assign out_data    = out_data_q;
  assign out_ctrl    = out_ctrl_q;
  assign tokens      = tokens_q;
  assign pkt_sent    = pkt_sent_q;
  assign pkt_delayed = pkt_delayed_q;

endmodule

// File: tb/tb_oq_rate_limiter.sv
// Directed bench for oq_rate_limiter: bypass, shaping, saturation, simultaneous refill/deduct,
// backpressure and mid-packet reset, checked against hand-computed values and a word scoreboard.
module tb_oq_rate_limiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_inc = '0;
  logic [15:0] cfg_interval = '0;
  logic [19:0] cfg_bucket_max = '0;
  logic [19:0] tokens;
  logic        pkt_sent;
  logic        pkt_delayed;

  oq_rate_limiter dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_ctrl        (in_ctrl),
    .in_wr          (in_wr),
    .in_rdy         (in_rdy),
    .out_data       (out_data),
    .out_ctrl       (out_ctrl),
    .out_wr         (out_wr),
    .out_rdy        (out_rdy),
    .cfg_enable     (cfg_enable),
    .cfg_inc        (cfg_inc),
    .cfg_interval   (cfg_interval),
    .cfg_bucket_max (cfg_bucket_max),
    .tokens         (tokens),
    .pkt_sent       (pkt_sent),
    .pkt_delayed    (pkt_delayed)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [63:0] out_d   [1024];
  logic [7:0]  out_c   [1024];
  int          out_cyc [1024];
  logic [19:0] out_tok [1024];
  int out_n = 0;
  int sent_n = 0;
  int dly_n = 0;

  always @(negedge clk) begin
    if (out_wr && out_n < 1024) begin
      out_d[out_n]   <= out_data;
      out_c[out_n]   <= out_ctrl;
      out_cyc[out_n] <= cyc;
      out_tok[out_n] <= tokens;
      out_n          <= out_n + 1;
    end
    if (pkt_sent)    sent_n <= sent_n + 1;
    if (pkt_delayed) dly_n  <= dly_n + 1;
  end

  logic [63:0] exp_d [256];
  logic [7:0]  exp_c [256];
  int exp_n = 0;
  int extra = 0;
  logic toggle = 1'b0;
  int ob, sb, db, rel;

  function automatic logic [63:0] pat(input int p, input int i);
    return {p[7:0], 8'h5A, i[15:0], 32'hC0DE_0000 ^ i};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (toggle) out_rdy = ~out_rdy;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic record(input logic [63:0] d, input logic [7:0] c);
    exp_d[exp_n] = d;
    exp_c[exp_n] = c;
    exp_n++;
  endtask

  // Writes one word; up to two extra words are allowed after in_rdy falls.
  task automatic put(input logic [63:0] d, input logic [7:0] c);
    int waited = 0;
    while (!(in_rdy || extra < 2) && waited < 1000) begin
      in_wr = 1'b0;
      tick();
      waited++;
    end
    if (waited >= 1000) begin
      tests++;
      fails++;
      $error("FAIL put_timeout: got %0d cycles waiting, required < 1000", waited);
    end
    if (in_rdy) extra = 0;
    else extra++;
    in_wr   = 1'b1;
    in_data = d;
    in_ctrl = c;
    record(d, c);
    tick();
  endtask

  task automatic idle();
    in_wr = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 64'(out_n - ob), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      check($sformatf("%s_d%0d", tag, i), out_d[ob + i], exp_d[i]);
      check($sformatf("%s_c%0d", tag, i), 64'(out_c[ob + i]), 64'(exp_c[i]));
    end
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_out_wr", out_wr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_tokens", tokens, 0);
    check("rst_pkt_sent", pkt_sent, 0);
    check("rst_pkt_delayed", pkt_delayed, 0);
    check("rst_in_rdy", in_rdy, 1);

    // Bypass: 60-byte packet, shaping off, bucket empty
    tick();
    reset = 1'b1;
    exp_n = 0; ob = out_n; sb = sent_n; db = dly_n;
    put(64'h0000_0000_0000_003C, 8'hFF);
    check("byp_lat1", out_wr, 0);
    put(pat(1, 1), 8'h00);
    check("byp_lat2_wr", out_wr, 1);
    check("byp_lat2_data", out_data, 64'h0000_0000_0000_003C);
    for (int i = 2; i <= 8; i++) put(pat(1, i), (i == 8) ? 8'h01 : 8'h00);
    idle();
    repeat (6) tick();
    check_stream("byp");
    check("byp_sent", 64'(sent_n - sb), 1);
    check("byp_delayed", 64'(dly_n - db), 0);
    check("byp_tokens", tokens, 0);

    // Shaping: 1500-byte packet waits for 24 refills of 64
    reset = 1'b0;
    cfg_enable = 1'b1; cfg_inc = 16'd64; cfg_interval = 16'd8; cfg_bucket_max = 20'd4096;
    tick();
    reset = 1'b1;
    rel = cyc;
    exp_n = 0; ob = out_n; sb = sent_n; db = dly_n;
    put({16'hA5A5, 32'h0, 16'd1500}, 8'hFF);
    for (int i = 1; i <= 188; i++) put(pat(2, i), (i == 188) ? 8'h01 : 8'h00);
    idle();
    repeat (10) tick();
    check_stream("shp");
    check("shp_delayed", 64'(dly_n - db), 1);
    check("shp_sent", 64'(sent_n - sb), 1);
    check("shp_first_cyc", 64'(out_cyc[ob]), 64'(rel + 193));
    check("shp_tok_after", out_tok[ob], 36);

    // Saturation and ceiling drop
    cfg_inc = 16'd1000; cfg_interval = 16'd1; cfg_bucket_max = 20'd3000;
    repeat (10) tick();
    check("sat_max", tokens, 3000);
    cfg_bucket_max = 20'd500;
    tick();
    check("sat_clamp", tokens, 500);

    // Refill of 64 lands in the admission cycle of a 100-byte packet
    reset = 1'b0;
    cfg_enable = 1'b1; cfg_inc = 16'd100; cfg_interval = 16'd4; cfg_bucket_max = 20'd4096;
    tick();
    reset = 1'b1;
    exp_n = 0; ob = out_n; sb = sent_n; db = dly_n;
    repeat (4) tick();
    check("sim_tok_pre", tokens, 100);
    cfg_inc = 16'd64;
    repeat (2) tick();
    put({48'h0, 16'd100}, 8'hFF);
    check("sim_tok_hold", tokens, 100);
    check("sim_wr_hold", out_wr, 0);
    put(pat(4, 1), 8'h00);
    check("sim_tok", tokens, 64);
    check("sim_head_wr", out_wr, 1);
    check("sim_head_data", out_data, {48'h0, 16'd100});
    for (int i = 2; i <= 13; i++) put(pat(4, i), (i == 13) ? 8'h01 : 8'h00);
    idle();
    repeat (8) tick();
    check_stream("sim");
    check("sim_sent", 64'(sent_n - sb), 1);
    check("sim_delayed", 64'(dly_n - db), 0);

    // Backpressure: fill with out_rdy low, then toggle out_rdy every cycle
    cfg_enable = 1'b0;
    out_rdy = 1'b0;
    exp_n = 0; ob = out_n; sb = sent_n;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_rdy%0d", i), in_rdy, (i < 6) ? 1 : 0);
      in_wr = 1'b1; in_data = pat(5, i); in_ctrl = (i == 0) ? 8'hFF : 8'h00;
      record(in_data, in_ctrl);
      tick();
    end
    idle();
    check("bp_full_rdy", in_rdy, 0);
    check("bp_hold_wr", out_wr, 0);
    extra = 2;
    toggle = 1'b1;
    for (int i = 8; i < 20; i++) put(pat(5, i), (i == 19) ? 8'h01 : 8'h00);
    idle();
    repeat (60) tick();
    toggle = 1'b0;
    out_rdy = 1'b1;
    repeat (5) tick();
    check_stream("bp");
    check("bp_sent", 64'(sent_n - sb), 1);

    // Reset in the middle of a packet
    cfg_inc = 16'd1000; cfg_interval = 16'd1; cfg_bucket_max = 20'd3000;
    repeat (5) tick();
    check("mr_tok_pre", tokens, 3000);
    exp_n = 0;
    for (int i = 0; i < 4; i++) put(pat(6, i), (i == 0) ? 8'hFF : 8'h00);
    idle();
    check("mr_busy", out_wr, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_out_wr", out_wr, 0);
    check("mr_out_data", out_data, 0);
    check("mr_out_ctrl", out_ctrl, 0);
    check("mr_tokens", tokens, 0);
    check("mr_pkt_sent", pkt_sent, 0);
    check("mr_in_rdy", in_rdy, 1);
    tick();
    reset = 1'b1;
    extra = 0;
    exp_n = 0; ob = out_n; sb = sent_n;
    for (int i = 0; i < 5; i++) put(pat(7, i), (i == 0) ? 8'hFF : ((i == 4) ? 8'h01 : 8'h00));
    idle();
    repeat (8) tick();
    check_stream("mr");
    check("mr_sent", 64'(sent_n - sb), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
